// File: rtl/load_store_unit.sv
// load_store_unit
//   Load/store unit sitting between the cpu datapath and data memory.
//   Accepts one RV32I load/store at a time, checks it for faults, runs a
//   registered req/ack memory handshake with byte-lane steering, and returns
//   a one-cycle response carrying the extended load data or a fault code.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   req_valid/ready    cpu request handshake (ready only while idle)
//   req_we             1 = store, 0 = load
//   req_funct3         RV32I funct3 of the access
//   req_addr           effective byte address
//   req_wdata          store data (rs2)
//   rsp_valid          one-cycle completion pulse
//   rsp_rdata          extended load result, 0 for stores and faults
//   rsp_err            fault flag
//   rsp_err_code       0 none, 1 misaligned, 2 access fault, 3 illegal funct3
//   mem_req            memory request, held until mem_ack
//   mem_we             memory write enable
//   mem_be             byte enables
//   mem_addr           word address (byte address bits ADDR_W-1:2)
//   mem_wdata          lane-replicated store data
//   mem_ack            memory completion, read data valid in the same cycle
//   mem_rdata          memory read word

module load_store_unit #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        rsp_err_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value during the last permitted ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_ACCESS   = 2'd2;
  localparam logic [1:0] ERR_FUNCT3   = 2'd3;

  state_t             state_q, state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [1:0]         offset_q, offset_d;
  logic               we_q, we_d;
  logic [3:0]         be_q, be_d;
  logic [ADDR_W-3:0]  maddr_q, maddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Request decode, evaluated combinationally from the cpu inputs.
  logic        illegal_f3;
  logic        misaligned;
  logic        out_of_range;
  logic [1:0]  req_size;
  logic [3:0]  req_be;
  logic [31:0] req_lane_data;

  // Load extraction from the memory word.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  assign req_size = req_funct3[1:0];

  always_comb begin
    illegal_f3    = 1'b0;
    misaligned    = 1'b0;
    out_of_range  = 1'b0;
    req_be        = 4'hF;
    req_lane_data = req_wdata;

    if (req_we)
      illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal_f3 = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

    misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    out_of_range = |req_addr[31:ADDR_W];

    case (req_size)
      2'b00: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_be        = 4'b0011 << {req_addr[1], 1'b0};
        req_lane_data = {2{req_wdata[15:0]}};
      end
      default: begin
        req_be        = 4'hF;
        req_lane_data = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte   = 8'h00;
    ld_half   = 16'h0000;
    ld_result = 32'h0;

    case (offset_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (funct3_q)
      3'b000:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_result = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_result = mem_rdata;
      3'b100:  ld_result = {24'h0, ld_byte};
      3'b101:  ld_result = {16'h0, ld_half};
      default: ld_result = 32'h0;
    endcase
  end

  // Next-state logic. The memory-side registers are loaded on accept and
  // cleared on leaving ACCESS; the response registers are only non-zero
  // during RESP, so the outputs can be driven straight from the flops.
  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
    we_d     = we_q;
    be_d     = be_q;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    code_d   = ERR_NONE;
    cnt_d    = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct3_d = req_funct3;
          offset_d = req_addr[1:0];
          if (illegal_f3) begin
            state_d = RESP;
            err_d   = 1'b1;
            code_d  = ERR_FUNCT3;
          end else if (misaligned) begin
            state_d = RESP;
            err_d   = 1'b1;
            code_d  = ERR_MISALIGN;
          end else if (out_of_range) begin
            state_d = RESP;
            err_d   = 1'b1;
            code_d  = ERR_ACCESS;
          end else begin
            state_d = ACCESS;
            we_d    = req_we;
            be_d    = req_be;
            maddr_d = req_addr[ADDR_W-1:2];
            wdata_d = req_we ? req_lane_data : 32'h0;
          end
        end
      end

      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the expiry cycle takes precedence over the timeout.
        if (mem_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'h0 : ld_result;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          state_d = RESP;
          err_d   = 1'b1;
          code_d  = ERR_ACCESS;
        end
        if (state_d == RESP) begin
          we_d    = 1'b0;
          be_d    = 4'h0;
          maddr_d = '0;
          wdata_d = 32'h0;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      funct3_q <= 3'b000;
      offset_q <= 2'b00;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      maddr_q  <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
      we_q     <= we_d;
      be_q     <= be_d;
      maddr_q  <= maddr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      code_q   <= code_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign mem_req      = (state_q == ACCESS);
  assign mem_we       = we_q;
  assign mem_be       = be_q;
  assign mem_addr     = maddr_q;
  assign mem_wdata    = wdata_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign rsp_err_code = code_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clock;
   logic        rstN;
   logic        reqValid;
   logic        reqReady;
   logic        reqWe;
   logic [2:0]  reqFunct3;
   logic [31:0] reqAddr;
   logic [31:0] reqWdata;
   logic        rspValid;
   logic [31:0] rspRdata;
   logic        rspErr;
   logic [1:0]  rspErrCode;
   logic        memReq;
   logic        memWe;
   logic [3:0]  memBe;
   logic [7:0]  memAddr;
   logic [31:0] memWdata;
   logic        memAck;
   logic [31:0] memRdata;

   int checkCount = 0;
   int failCount  = 0;

   load_store_unit #(.ADDR_W(10), .TIMEOUT(4)) dut (
      .clk(clock),
      .rst_n(rstN),
      .req_valid(reqValid),
      .req_ready(reqReady),
      .req_we(reqWe),
      .req_funct3(reqFunct3),
      .req_addr(reqAddr),
      .req_wdata(reqWdata),
      .rsp_valid(rspValid),
      .rsp_rdata(rspRdata),
      .rsp_err(rspErr),
      .rsp_err_code(rspErrCode),
      .mem_req(memReq),
      .mem_we(memWe),
      .mem_be(memBe),
      .mem_addr(memAddr),
      .mem_wdata(memWdata),
      .mem_ack(memAck),
      .mem_rdata(memRdata)
   );

   // Free-running clock, 10 time units per period.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // One comparison: count it, and report on mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Present one request while idle; returns at the negedge after the accept edge.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clock);
      checkOutput("req_ready idle", reqReady, 1);
      reqValid  = 1'b1;
      reqWe     = we;
      reqFunct3 = f3;
      reqAddr   = addr;
      reqWdata  = wdata;
      @(negedge clock);
      reqValid  = 1'b0;
   endtask

   // Check the memory side, ack after ackWait extra cycles, then check the response.
   task automatic memAccess(input string tag, input logic expWe, input logic [3:0] expBe,
                            input logic [31:0] expAddr, input logic checkWdata, input logic [31:0] expWdata,
                            input int ackWait, input logic [31:0] rdata, input logic [31:0] expRdata);
      checkOutput({tag, " mem_req"}, memReq, 1);
      checkOutput({tag, " mem_we"}, memWe, expWe);
      checkOutput({tag, " mem_be"}, memBe, expBe);
      checkOutput({tag, " mem_addr"}, memAddr, expAddr);
      if (checkWdata) checkOutput({tag, " mem_wdata"}, memWdata, expWdata);
      checkOutput({tag, " req_ready busy"}, reqReady, 0);
      for (int i = 0; i < ackWait; i++) begin
         @(negedge clock);
         checkOutput({tag, " mem_req held"}, memReq, 1);
         checkOutput({tag, " mem_be held"}, memBe, expBe);
      end
      memRdata = rdata;
      memAck   = 1'b1;
      @(negedge clock);
      memAck   = 1'b0;
      memRdata = 32'h5555_AAAA;
      checkOutput({tag, " rsp_valid"}, rspValid, 1);
      checkOutput({tag, " rsp_err"}, rspErr, 0);
      checkOutput({tag, " rsp_code"}, rspErrCode, 0);
      checkOutput({tag, " rsp_rdata"}, rspRdata, expRdata);
      checkOutput({tag, " mem_req off"}, memReq, 0);
      checkOutput({tag, " mem_be off"}, memBe, 0);
      @(negedge clock);
      checkOutput({tag, " rsp_valid pulse"}, rspValid, 0);
      checkOutput({tag, " rsp_rdata off"}, rspRdata, 0);
   endtask

   // A faulting request answers one cycle after accept with no memory access.
   task automatic faultOp(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] expCode);
      applyStimulus(we, f3, addr, 32'hFFFF_FFFF);
      checkOutput({tag, " mem_req"}, memReq, 0);
      checkOutput({tag, " rsp_valid"}, rspValid, 1);
      checkOutput({tag, " rsp_err"}, rspErr, 1);
      checkOutput({tag, " rsp_code"}, rspErrCode, expCode);
      checkOutput({tag, " rsp_rdata"}, rspRdata, 0);
      @(negedge clock);
      checkOutput({tag, " rsp_valid pulse"}, rspValid, 0);
      checkOutput({tag, " mem_req after"}, memReq, 0);
   endtask

   // Directed sequence.
   initial begin
      rstN      = 1'b0;
      reqValid  = 1'b0;
      reqWe     = 1'b0;
      reqFunct3 = 3'b000;
      reqAddr   = 32'h0;
      reqWdata  = 32'h0;
      memAck    = 1'b0;
      memRdata  = 32'h0;

      repeat (2) @(negedge clock);
      checkOutput("reset req_ready", reqReady, 1);
      checkOutput("reset mem_req", memReq, 0);
      checkOutput("reset rsp_valid", rspValid, 0);
      checkOutput("reset mem_be", memBe, 0);
      rstN = 1'b1;

      // mem_ack while idle must not produce anything.
      @(negedge clock);
      memAck = 1'b1;
      @(negedge clock);
      memAck = 1'b0;
      checkOutput("idle ack rsp_valid", rspValid, 0);
      checkOutput("idle ack mem_req", memReq, 0);

      $display("[TB] loads");
      applyStimulus(1'b0, 3'b000, 32'h003, 32'h0);
      memAccess("LB 3", 1'b0, 4'b1000, 0, 1'b0, 32'h0, 1, 32'h80FF_1234, 32'hFFFF_FF80);
      applyStimulus(1'b0, 3'b101, 32'h002, 32'h0);
      memAccess("LHU 2", 1'b0, 4'b1100, 0, 1'b0, 32'h0, 0, 32'hBEEF_0000, 32'h0000_BEEF);
      applyStimulus(1'b0, 3'b001, 32'h002, 32'h0);
      memAccess("LH 2", 1'b0, 4'b1100, 0, 1'b0, 32'h0, 0, 32'hBEEF_0000, 32'hFFFF_BEEF);
      applyStimulus(1'b0, 3'b100, 32'h001, 32'h0);
      memAccess("LBU 1", 1'b0, 4'b0010, 0, 1'b0, 32'h0, 2, 32'h1234_F600, 32'h0000_00F6);
      applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0);
      memAccess("LW 3FC", 1'b0, 4'hF, 32'hFF, 1'b0, 32'h0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);

      $display("[TB] stores");
      applyStimulus(1'b1, 3'b001, 32'h006, 32'h1234_ABCD);
      memAccess("SH 6", 1'b1, 4'b1100, 1, 1'b1, 32'hABCD_ABCD, 0, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1'b1, 3'b000, 32'h009, 32'h7777_775A);
      memAccess("SB 9", 1'b1, 4'b0010, 2, 1'b1, 32'h5A5A_5A5A, 1, 32'hDEAD_BEEF, 32'h0);
      applyStimulus(1'b1, 3'b010, 32'h010, 32'h0102_0304);
      memAccess("SW 10", 1'b1, 4'hF, 4, 1'b1, 32'h0102_0304, 0, 32'h0, 32'h0);

      $display("[TB] faults");
      faultOp("LW misaligned", 1'b0, 3'b010, 32'h002, 2'd1);
      faultOp("SW range", 1'b1, 3'b010, 32'h400, 2'd2);
      faultOp("load f3 011", 1'b0, 3'b011, 32'h000, 2'd3);
      faultOp("store f3 100", 1'b1, 3'b100, 32'h000, 2'd3);
      faultOp("LH mis+range", 1'b0, 3'b001, 32'h401, 2'd1);
      faultOp("f3 110 mis", 1'b0, 3'b110, 32'h001, 2'd3);

      $display("[TB] timeout");
      applyStimulus(1'b0, 3'b010, 32'h000, 32'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput("timeout mem_req high", memReq, 1);
         @(negedge clock);
      end
      checkOutput("timeout mem_req low", memReq, 0);
      checkOutput("timeout rsp_valid", rspValid, 1);
      checkOutput("timeout rsp_err", rspErr, 1);
      checkOutput("timeout rsp_code", rspErrCode, 2);
      checkOutput("timeout rsp_rdata", rspRdata, 0);
      @(negedge clock);
      checkOutput("timeout rsp pulse", rspValid, 0);
      applyStimulus(1'b0, 3'b010, 32'h000, 32'h0);
      memAccess("ack on cycle 4", 1'b0, 4'hF, 0, 1'b0, 32'h0, 3, 32'h1357_9BDF, 32'h1357_9BDF);

      $display("[TB] reset mid-access");
      applyStimulus(1'b0, 3'b010, 32'h008, 32'h0);
      checkOutput("pre-reset mem_req", memReq, 1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("async mem_req drop", memReq, 0);
      checkOutput("async req_ready", reqReady, 1);
      checkOutput("async mem_be", memBe, 0);
      #1 rstN = 1'b1;
      @(negedge clock);
      checkOutput("post-reset rsp_valid", rspValid, 0);
      checkOutput("post-reset mem_req", memReq, 0);
      applyStimulus(1'b0, 3'b010, 32'h000, 32'h0);
      memAccess("LW after reset", 1'b0, 4'hF, 0, 1'b0, 32'h0, 0, 32'h2468_ACE0, 32'h2468_ACE0);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule
